// File: rtl/lpc_host.sv
// -----------------------------------------------------------------------------
// lpc_host
// LPC bus initiator (host side). Issues single-byte I/O and TPM-locality read
// and write cycles to an LPC peripheral. Commands arrive on a valid/ready
// interface and complete with a one-clock response strobe. LAD is split into
// drive value, output enable and sampled input; the tri-state buffer is
// external to this block.
//
// Ports:
//   clk_i        LPC clock (LCLK)
//   rst_i        asynchronous active-high reset
//   req_valid_i  command valid
//   req_ready_o  high only while idle; command taken on valid & ready
//   req_write_i  1 = write cycle, 0 = read cycle
//   req_tpm_i    1 = TPM cycle (START 0101), 0 = I/O cycle (START 0000)
//   req_addr_i   16-bit cycle address
//   req_data_i   write data
//   rsp_valid_o  one-clock completion pulse
//   rsp_data_o   read data (0x00 for writes and aborted cycles)
//   rsp_err_o    error SYNC, wait timeout or no response
//   lframe_o     LFRAME#, active low
//   lad_o        LAD drive value
//   lad_oe_o     LAD output enable
//   lad_i        LAD sampled value
// -----------------------------------------------------------------------------
module lpc_host #(
    parameter int SHORT_WAIT_MAX = 8,
    parameter int LONG_WAIT_MAX  = 1024,
    parameter int NO_RESP_MAX    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_tpm_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_err_o,
    output logic        lframe_o,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    input  logic [3:0]  lad_i
);

    localparam int SW_W = $clog2(SHORT_WAIT_MAX + 1);
    localparam int LW_W = $clog2(LONG_WAIT_MAX + 1);
    localparam int NR_W = $clog2(NO_RESP_MAX + 1);

    localparam logic [SW_W-1:0] SW_LIMIT = SW_W'(SHORT_WAIT_MAX);
    localparam logic [LW_W-1:0] LW_LIMIT = LW_W'(LONG_WAIT_MAX);
    localparam logic [NR_W-1:0] NR_LIMIT = NR_W'(NO_RESP_MAX);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_CYCDIR,
        S_ADDR,
        S_WDATA,
        S_TAR_H1,
        S_TAR_H2,
        S_SYNC,
        S_RDATA,
        S_TAR_P1,
        S_TAR_P2,
        S_ABORT,
        S_ABORT_REC,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;

    logic [SW_W-1:0]   r_short_cnt;
    logic [LW_W-1:0]   r_long_cnt;
    logic [NR_W-1:0]   r_none_cnt;
    logic [SW_W-1:0]   w_short_inc;
    logic [LW_W-1:0]   w_long_inc;
    logic [NR_W-1:0]   w_none_inc;

    logic              r_err;
    logic [7:0]        r_rsp_data;
    logic              r_rsp_err;

    // Latched command; captured on acceptance and held for the whole cycle
    logic              r_write;
    logic              r_tpm;
    logic [15:0]       r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_rdata;

    logic              w_accept;
    logic              w_code_ready;
    logic              w_code_short;
    logic              w_code_long;
    logic              w_code_none;
    logic              w_code_err;

    logic [3:0]        w_lad;
    logic              w_lad_oe;
    logic              w_lframe;

    assign w_accept     = (r_state == S_IDLE) && req_valid_i;

    assign w_code_ready = (lad_i == 4'h0);
    assign w_code_short = (lad_i == 4'h5);
    assign w_code_long  = (lad_i == 4'h6);
    assign w_code_none  = (lad_i == 4'hF);
    // 1010 and every unrecognised code are treated alike as an error SYNC
    assign w_code_err   = ~(w_code_ready | w_code_short | w_code_long | w_code_none);

    assign w_short_inc  = r_short_cnt + 1'b1;
    assign w_long_inc   = r_long_cnt + 1'b1;
    assign w_none_inc   = r_none_cnt + 1'b1;

    // Control state; reset forces the idle bus immediately, no abort sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_short_cnt <= '0;
            r_long_cnt  <= '0;
            r_none_cnt  <= '0;
            r_err       <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            // Each wait counter only survives consecutive samples of its code
            if (r_state == S_SYNC) begin
                r_short_cnt <= w_code_short ? w_short_inc : '0;
                r_long_cnt  <= w_code_long  ? w_long_inc  : '0;
                r_none_cnt  <= w_code_none  ? w_none_inc  : '0;
            end else begin
                r_short_cnt <= '0;
                r_long_cnt  <= '0;
                r_none_cnt  <= '0;
            end

            if (w_accept) begin
                r_err <= 1'b0;
            end else if (((r_state == S_SYNC) && w_code_err) || (r_state == S_ABORT)) begin
                r_err <= 1'b1;
            end

            // Both paths into DONE pass through one of these states, so the
            // response is registered exactly one clock before the strobe
            if ((r_state == S_TAR_P2) || (r_state == S_ABORT_REC)) begin
                r_rsp_data <= (r_write || (r_state == S_ABORT_REC)) ? 8'h00 : r_rdata;
                r_rsp_err  <= r_err;
            end
        end
    end

    // Command and read-data holding registers; only meaningful inside a cycle
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_write <= req_write_i;
            r_tpm   <= req_tpm_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_data_i;
        end
        if (r_state == S_RDATA) begin
            if (r_cnt[0]) begin
                r_rdata[7:4] <= lad_i;
            end else begin
                r_rdata[3:0] <= lad_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lad       = 4'hF;
        w_lad_oe    = 1'b0;
        w_lframe    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                w_lad       = r_tpm ? 4'h5 : 4'h0;
                w_lad_oe    = 1'b1;
                w_lframe    = 1'b0;
                w_state_nxt = S_CYCDIR;
            end
            S_CYCDIR: begin
                w_lad       = {2'b00, r_write, 1'b0};
                w_lad_oe    = 1'b1;
                w_state_nxt = S_ADDR;
                w_cnt_nxt   = '0;
            end
            S_ADDR: begin
                w_lad_oe = 1'b1;
                case (r_cnt)
                    2'd0:    w_lad = r_addr[15:12];
                    2'd1:    w_lad = r_addr[11:8];
                    2'd2:    w_lad = r_addr[7:4];
                    default: w_lad = r_addr[3:0];
                endcase
                if (r_cnt == 2'd3) begin
                    w_state_nxt = r_write ? S_WDATA : S_TAR_H1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_WDATA: begin
                w_lad_oe = 1'b1;
                w_lad    = r_cnt[0] ? r_wdata[7:4] : r_wdata[3:0];
                if (r_cnt[0]) begin
                    w_state_nxt = S_TAR_H1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = 2'd1;
                end
            end
            S_TAR_H1: begin
                w_lad_oe    = 1'b1;
                w_state_nxt = S_TAR_H2;
            end
            S_TAR_H2: begin
                w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (w_code_short) begin
                    if (w_short_inc == SW_LIMIT) begin
                        w_state_nxt = S_ABORT;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_code_long) begin
                    if (w_long_inc == LW_LIMIT) begin
                        w_state_nxt = S_ABORT;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_code_none) begin
                    if (w_none_inc == NR_LIMIT) begin
                        w_state_nxt = S_ABORT;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    // Ready or error: the cycle proceeds normally either way
                    w_state_nxt = r_write ? S_TAR_P1 : S_RDATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_RDATA: begin
                if (r_cnt[0]) begin
                    w_state_nxt = S_TAR_P1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = 2'd1;
                end
            end
            S_TAR_P1: begin
                w_state_nxt = S_TAR_P2;
            end
            S_TAR_P2: begin
                w_state_nxt = S_DONE;
            end
            S_ABORT: begin
                w_lad_oe = 1'b1;
                w_lframe = 1'b0;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = S_ABORT_REC;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            S_ABORT_REC: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_DONE);
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign lframe_o    = w_lframe;
    assign lad_o       = w_lad;
    assign lad_oe_o    = w_lad_oe;

endmodule

// File: tb/tb_lpc_host.sv
`timescale 1ns/1ps
module tb_lpc_host;

    localparam int SW_MAX = 8;
    localparam int LW_MAX = 1024;
    localparam int NR_MAX = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic        req_tpm_i;
    logic [15:0] req_addr_i;
    logic [7:0]  req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic        lframe_o;
    logic [3:0]  lad_o;
    logic        lad_oe_o;
    logic [3:0]  lad_i;

    always #5 clk_i = ~clk_i;

    lpc_host #(
        .SHORT_WAIT_MAX (SW_MAX),
        .LONG_WAIT_MAX  (LW_MAX),
        .NO_RESP_MAX    (NR_MAX)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_tpm_i   (req_tpm_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .lframe_o    (lframe_o),
        .lad_o       (lad_o),
        .lad_oe_o    (lad_oe_o),
        .lad_i       (lad_i)
    );

    int checks = 0;
    int errors = 0;

    // Peripheral responder state
    int         p_phase = 0;
    int         p_j = 0;
    logic [7:0] p_rd = 8'h00;
    logic [7:0] rd_q[$];
    logic [3:0] g_sync[$];

    typedef struct {
        bit         wr;
        bit         tpm;
        bit [15:0]  addr;
        bit [7:0]   data;
        bit [7:0]   rd;
        int         nwait;
        bit [3:0]   wcode;
        bit [3:0]   fcode;
        int         exp_lat;
        bit         exp_err;
        bit [7:0]   exp_data;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int wait_max(input logic [3:0] code);
        if (code == 4'h5) return SW_MAX;
        if (code == 4'h6) return LW_MAX;
        return NR_MAX;
    endfunction

    function automatic bit is_wait(input logic [3:0] code);
        return (code == 4'h5) || (code == 4'h6) || (code == 4'hF);
    endfunction

    // Reference: walk the SYNC codes the peripheral will present, counting
    // runs of each wait code; header length and tail length give latency.
    task automatic model(input bit wr, input logic [7:0] rd, output int lat,
                         output bit err, output logic [7:0] dat, output bit abort);
        int h;
        int run;
        bit fin;
        logic [3:0] prev;
        logic [3:0] code;
        h = wr ? 10 : 8;
        run = 0; prev = 4'h0; fin = 0;
        abort = 0; err = 0; dat = 8'h00; lat = -1;
        for (int j = 0; j < 4000 && !fin; j++) begin
            code = (j < g_sync.size()) ? g_sync[j] : g_sync[g_sync.size()-1];
            if (is_wait(code)) begin
                run  = (code == prev) ? run + 1 : 1;
                prev = code;
                if (run == wait_max(code)) begin
                    abort = 1; err = 1; dat = 8'h00;
                    lat = h + j + 1 + 5;
                    fin = 1;
                end
            end else begin
                err = (code != 4'h0);
                dat = wr ? 8'h00 : rd;
                lat = h + j + 1 + (wr ? 0 : 2) + 2;
                fin = 1;
            end
        end
    endtask

    // Called once per clock at the falling edge; reacts to what the host drives
    task automatic periph_step();
        logic [3:0] code;
        case (p_phase)
            0: begin
                if (!lframe_o && lad_oe_o && lad_o != 4'hF) begin
                    p_phase = 1;
                    p_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                end
            end
            1: begin
                if (!lad_oe_o) begin
                    p_phase = 2;
                    p_j = 0;
                end
            end
            2: begin
                if (!lframe_o) begin
                    p_phase = 0;
                    lad_i = 4'hF;
                end else begin
                    code = (p_j < g_sync.size()) ? g_sync[p_j] : g_sync[g_sync.size()-1];
                    lad_i = code;
                    p_j++;
                    if (!is_wait(code)) p_phase = 3;
                end
            end
            3: begin lad_i = p_rd[3:0]; p_phase = 4; end
            4: begin lad_i = p_rd[7:4]; p_phase = 5; end
            default: begin lad_i = 4'hF; p_phase = 0; end
        endcase
    endtask

    task automatic run_txn(input string tag, input bit wr, input bit tpm,
                           input logic [15:0] addr, input logic [7:0] data, input logic [7:0] rd,
                           output int lat, output logic err, output logic [7:0] dat);
        int m_lat;
        bit m_err;
        logic [7:0] m_dat;
        bit m_abort;
        logic [4:0] exp_q[$];
        logic [4:0] act_q[$];
        int tar_idx;
        bit bad_lf;
        bit bad_rdy;
        bit done;
        int waitc;
        int nmin;

        model(wr, rd, m_lat, m_err, m_dat, m_abort);
        exp_q.push_back({1'b0, (tpm ? 4'h5 : 4'h0)});
        exp_q.push_back({1'b1, 2'b00, wr, 1'b0});
        exp_q.push_back({1'b1, addr[15:12]});
        exp_q.push_back({1'b1, addr[11:8]});
        exp_q.push_back({1'b1, addr[7:4]});
        exp_q.push_back({1'b1, addr[3:0]});
        if (wr) begin
            exp_q.push_back({1'b1, data[3:0]});
            exp_q.push_back({1'b1, data[7:4]});
        end
        exp_q.push_back(5'h1F);
        if (m_abort) repeat (4) exp_q.push_back(5'h0F);

        rd_q.delete();
        rd_q.push_back(rd);
        waitc = 0;
        @(posedge clk_i); #1;
        while (!req_ready_o && waitc < 50) begin
            @(posedge clk_i); #1;
            waitc++;
        end
        chk({tag, "/idle"}, req_ready_o, 1);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_tpm_i   = tpm;
        req_addr_i  = addr;
        req_data_i  = data;
        @(posedge clk_i); #1;
        // Command must already be latched; disturb the request inputs
        req_valid_i = 1'b0;
        req_write_i = ~wr;
        req_tpm_i   = ~tpm;
        req_addr_i  = ~addr;
        req_data_i  = ~data;

        done = 0; tar_idx = -1; bad_lf = 0; bad_rdy = 0;
        lat = -1; err = 1'b0; dat = 8'h00;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk_i);
            if (req_ready_o) bad_rdy = 1;
            if (rsp_valid_o) begin
                done = 1; lat = k; err = rsp_err_o; dat = rsp_data_o;
            end else begin
                if (lad_oe_o) act_q.push_back({lframe_o, lad_o});
                else if (!lframe_o) bad_lf = 1;
                if (!lad_oe_o && tar_idx < 0) tar_idx = k;
            end
            periph_step();
        end

        chk({tag, "/completed"}, done, 1);
        if (done) begin
            chk({tag, "/latency"}, lat, m_lat);
            chk({tag, "/err"}, err, m_err);
            chk({tag, "/data"}, dat, m_dat);
            chk({tag, "/tar_h2_clock"}, tar_idx, wr ? 9 : 7);
            chk({tag, "/lframe_without_oe"}, bad_lf, 0);
            chk({tag, "/ready_in_cycle"}, bad_rdy, 0);
            chk({tag, "/bus_len"}, act_q.size(), exp_q.size());
            nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
            for (int i = 0; i < nmin; i++)
                chk($sformatf("%s/bus[%0d]", tag, i), act_q[i], exp_q[i]);
            @(negedge clk_i);
            chk({tag, "/pulse_one_clock"}, rsp_valid_o, 0);
            chk({tag, "/data_hold"}, rsp_data_o, m_dat);
            chk({tag, "/err_hold"}, rsp_err_o, m_err);
        end
        lad_i = 4'hF;
        p_phase = 0;
    endtask

    initial begin
        int lat;
        logic err;
        logic [7:0] dat;
        int got;
        int idx;
        bit acc;
        bit prev_done;
        logic [7:0] exp_rsp[$];
        bit b_wr[6];
        logic [15:0] b_addr[6];
        logic [7:0] b_data[6];
        logic [7:0] b_rd[6];
        logic [3:0] fcodes[6];

        tbl[0]  = '{1, 1, 16'h0018, 8'hA5, 8'h00, 0,    4'h5, 4'h0, 13,   0, 8'h00};
        tbl[1]  = '{0, 0, 16'h0F24, 8'h00, 8'hC3, 3,    4'h6, 4'h0, 16,   0, 8'hC3};
        tbl[2]  = '{0, 0, 16'h1234, 8'h00, 8'h55, 3,    4'hF, 4'h0, 16,   1, 8'h00};
        tbl[3]  = '{1, 0, 16'h0080, 8'h11, 8'h00, 0,    4'h5, 4'hA, 13,   1, 8'h00};
        tbl[4]  = '{1, 1, 16'h0002, 8'h33, 8'h00, 9,    4'h5, 4'h0, 23,   1, 8'h00};
        tbl[5]  = '{1, 0, 16'h00FF, 8'h3C, 8'h00, 7,    4'h5, 4'h0, 20,   0, 8'h00};
        tbl[6]  = '{0, 1, 16'hFFFF, 8'h00, 8'h7E, 2,    4'hF, 4'h0, 15,   0, 8'h7E};
        tbl[7]  = '{0, 0, 16'h4321, 8'h00, 8'h99, 0,    4'h5, 4'hA, 13,   1, 8'h99};
        tbl[8]  = '{0, 0, 16'h8000, 8'h00, 8'h42, 0,    4'h5, 4'h3, 13,   1, 8'h42};
        tbl[9]  = '{0, 0, 16'h0100, 8'h00, 8'h18, 1023, 4'h6, 4'h0, 1036, 0, 8'h18};
        tbl[10] = '{1, 0, 16'h0200, 8'h77, 8'h00, 1024, 4'h6, 4'h0, 1039, 1, 8'h00};
        tbl[11] = '{0, 1, 16'hC0DE, 8'h00, 8'hAB, 3,    4'h5, 4'h0, 16,   0, 8'hAB};

        rst_i = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_tpm_i = 1'b0;
        req_addr_i = 16'h0000; req_data_i = 8'h00;
        lad_i = 4'hF;
        #1;
        chk("reset/ready", req_ready_o, 1);
        chk("reset/rsp_valid", rsp_valid_o, 0);
        chk("reset/rsp_data", rsp_data_o, 8'h00);
        chk("reset/rsp_err", rsp_err_o, 0);
        chk("reset/lframe", lframe_o, 1);
        chk("reset/lad", lad_o, 4'hF);
        chk("reset/lad_oe", lad_oe_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Directed vectors
        for (int v = 0; v < 12; v++) begin
            g_sync.delete();
            for (int n = 0; n < tbl[v].nwait; n++) g_sync.push_back(tbl[v].wcode);
            g_sync.push_back(tbl[v].fcode);
            run_txn($sformatf("vec%0d", v), tbl[v].wr, tbl[v].tpm, tbl[v].addr,
                    tbl[v].data, tbl[v].rd, lat, err, dat);
            chk($sformatf("vec%0d/tbl_latency", v), lat, tbl[v].exp_lat);
            chk($sformatf("vec%0d/tbl_err", v), err, tbl[v].exp_err);
            chk($sformatf("vec%0d/tbl_data", v), dat, tbl[v].exp_data);
        end

        // Reset during the second address nibble
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_tpm_i = 1'b0;
        req_addr_i = 16'hABCD; req_data_i = 8'h5A;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("rstmid/addr_nibble2", lad_o, 4'hB);
        chk("rstmid/oe_before", lad_oe_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rstmid/lframe", lframe_o, 1);
        chk("rstmid/lad_oe", lad_oe_o, 0);
        chk("rstmid/ready", req_ready_o, 1);
        chk("rstmid/rsp_valid", rsp_valid_o, 0);
        chk("rstmid/rsp_data", rsp_data_o, 8'h00);
        @(negedge clk_i);
        rst_i = 1'b0;
        p_phase = 0;
        lad_i = 4'hF;
        g_sync.delete();
        g_sync.push_back(4'h0);
        run_txn("after_rst", 1'b0, 1'b1, 16'h0000, 8'h00, 8'h81, lat, err, dat);
        chk("after_rst/latency", lat, 13);
        chk("after_rst/err", err, 0);
        chk("after_rst/data", dat, 8'h81);

        // Randomized cycles against the reference model
        fcodes[0] = 4'h0; fcodes[1] = 4'h0; fcodes[2] = 4'h0;
        fcodes[3] = 4'hA; fcodes[4] = 4'h1; fcodes[5] = 4'h9;
        for (int r = 0; r < 30; r++) begin
            int nw;
            int sel;
            g_sync.delete();
            nw = $urandom_range(0, 6);
            for (int n = 0; n < nw; n++) begin
                sel = $urandom_range(0, 2);
                g_sync.push_back(sel == 0 ? 4'h5 : (sel == 1 ? 4'h6 : 4'hF));
            end
            g_sync.push_back(fcodes[$urandom_range(0, 5)]);
            run_txn($sformatf("rnd%0d", r), 1'($urandom), 1'($urandom), 16'($urandom),
                    8'($urandom), 8'($urandom), lat, err, dat);
        end

        // Held-valid back-to-back traffic, alternating read and write
        for (int i = 0; i < 6; i++) begin
            b_wr[i]   = (i % 2) == 1;
            b_addr[i] = 16'($urandom);
            b_data[i] = 8'($urandom);
            b_rd[i]   = 8'($urandom);
        end
        g_sync.delete();
        g_sync.push_back(4'h0);
        rd_q.delete();
        got = 0; idx = 0; prev_done = 0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_write_i = b_wr[0]; req_tpm_i = 1'b0;
        req_addr_i = b_addr[0]; req_data_i = b_data[0];
        for (int c = 0; c < 600 && got < 6; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                chk($sformatf("b2b%0d/order_data", got), rsp_data_o,
                    (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 8'hxx);
                chk($sformatf("b2b%0d/err", got), rsp_err_o, 0);
                chk($sformatf("b2b%0d/no_accept_in_done", got), req_ready_o, 0);
                got++;
                prev_done = 1;
            end else if (prev_done) begin
                chk($sformatf("b2b%0d/ready_after_done", got), req_ready_o, 1);
                prev_done = 0;
            end
            acc = req_valid_i && req_ready_o;
            if (acc) begin
                exp_rsp.push_back(b_wr[idx] ? 8'h00 : b_rd[idx]);
                rd_q.push_back(b_rd[idx]);
            end
            periph_step();
            @(posedge clk_i); #1;
            if (acc) begin
                idx++;
                if (idx < 6) begin
                    req_write_i = b_wr[idx];
                    req_addr_i  = b_addr[idx];
                    req_data_i  = b_data[idx];
                end else begin
                    req_valid_i = 1'b0;
                end
            end
        end
        chk("b2b/responses", got, 6);
        chk("b2b/accepted", idx, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_host.md
Name: lpc_host

Overview:
- LPC bus initiator (host side) that issues single-byte I/O and TPM-locality cycles to an LPC peripheral such as the TwPM LPC front end.
- Requests come from a valid/ready command interface; the byte is read back on a one-cycle response strobe.
- Serves as the host model in simulation and as an on-board LPC driver for loopback and bring-up builds.
- LAD is split into separate out, output-enable and in signals; the tri-state buffer sits outside the block.

Parameters:
- SHORT_WAIT_MAX, 8, maximum consecutive short-wait SYNCs (0101) before the cycle is aborted.
- LONG_WAIT_MAX, 1024, maximum consecutive long-wait SYNCs (0110) before the cycle is aborted.
- NO_RESP_MAX, 3, consecutive SYNC clocks reading 1111 before the cycle is aborted.

Ports:
- clk_i  in  1  LPC clock (LCLK domain); one clock only.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  high only in IDLE; a transfer happens when valid & ready.
- req_write_i  in  1  1 = write cycle, 0 = read cycle.
- req_tpm_i  in  1  1 = TPM cycle (START 0101), 0 = I/O cycle (START 0000).
- req_addr_i  in  16  cycle address.
- req_data_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  8  read data; valid with rsp_valid_o; 0x00 for writes.
- rsp_err_o  out  1  error sync, timeout or no response; valid with rsp_valid_o.
- lframe_o  out  1  LFRAME#, active low.
- lad_o  out  4  LAD drive value.
- lad_oe_o  out  1  LAD output enable.
- lad_i  in  4  LAD sampled value.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0x00, rsp_err_o=0, lframe_o=1, lad_o=4'hF, lad_oe_o=0.
- Reset is asynchronous. Asserting it mid-cycle forces the above values immediately, with no abort sequence. After release the block is in IDLE.
- On acceptance, address, data, direction and type are latched. Later changes on req_* are ignored until the next IDLE.
- One clock per state unless noted. Shown as lad_o / lad_oe_o / lframe_o:
  - START: 0101 (TPM) or 0000 (I/O) / 1 / 0.
  - CYCDIR: {2'b00, write, 1'b0} / 1 / 1.
  - ADDR (4 clocks): addr[15:12], [11:8], [7:4], [3:0] / 1 / 1.
  - WDATA (writes only, 2 clocks): data[3:0], then data[7:4].
  - TAR_H1: 1111 / 1.
  - TAR_H2: 1111 / 0. lad_oe_o stays 0 from here to the end of the cycle.
  - SYNC: lad_i is sampled each clock:
    - 0000: ready.
    - 1010: error; rsp_err_o is set and the cycle continues as if ready.
    - 0101: short wait; increments the short counter.
    - 0110: long wait; increments the long counter.
    - 1111: increments the no-response counter.
    - Any other value: error (same handling as 1010).
    - Each counter clears when a different code is sampled.
  - RDATA (reads only, 2 clocks): low nibble, then high nibble, sampled from lad_i.
  - TAR_P1, TAR_P2: peripheral turnaround; the host only observes.
  - DONE: rsp_valid_o=1 for one clock, then IDLE. rsp_data_o/rsp_err_o hold until the next DONE.
- Latency: acceptance to rsp_valid_o is 13 clocks when SYNC is ready on its first clock. Each wait SYNC adds 1 clock. Applies to both read and write.
- Abort: triggered when a counter reaches its MAX. The host then drives lframe_o=0, lad_o=1111, lad_oe_o=1 for 4 clocks. Next it drives lframe_o=1, lad_oe_o=0 for 1 clock, then DONE with rsp_err_o=1 and rsp_data_o=0x00.
- req_valid_i held high is not accepted in DONE. Back-to-back acceptance is possible from the first IDLE clock after DONE.

Test Plan:
1. TPM write, addr 0x0018, data 0xA5, peripheral SYNC 0000 on the first SYNC clock -> lad_o sequence 5,2,0,0,1,8,5,A,F with lframe_o low only on the first; lad_oe_o drops at TAR_H2; rsp_valid_o 13 clocks after acceptance, err=0.
2. I/O read, addr 0x0F24, SYNC 0110,0110,0110,0000, data nibbles 3 then C -> rsp_data_o=0xC3, err=0, latency 16 clocks.
3. Read with lad_i=1111 throughout SYNC -> abort after 3 SYNC clocks: lframe_o low for 4 clocks with lad_o=1111, then rsp_valid_o with err=1, data 0x00.
4. Write with SYNC 1010 -> normal TAR_P, rsp_valid_o at 13 clocks, err=1. Then SHORT_WAIT_MAX+1 consecutive 0101 SYNCs -> abort with err=1.
5. Assert rst_i during the second ADDR nibble -> same clock: lframe_o=1, lad_oe_o=0, req_ready_o=1. A following TPM read, addr 0x0000, returning 0x81 completes with err=0.
6. req_valid_i held high with alternating read/write requests -> each accepted only in IDLE; the response order matches the request order.
